reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_pkg.sv | 11 +
 rtl/reg_bank_if.sv | 37 +++
 rtl/reg_decoder.sv | 20 ++
 rtl/reg_bank.sv | 102 ++++++++++
 tb/tb_reg_bank.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants for the register bank: register count, select width,
// program-counter index and the default PC reset value and step.
package reg_bank_pkg;

    localparam int unsigned NUM_REGS     = 16;
    localparam int unsigned SEL_W        = 4;
    localparam int unsigned PC_IDX       = 15;
    localparam int unsigned PC_STEP_DEF  = 4;
    localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;

endpackage : reg_bank_pkg

// File: rtl/reg_bank_if.sv
// Write-side bus of the register bank.
//   wa_en/wa_sel/wa_data : port A (ALU result) write
//   wb_en/wb_sel/wb_data : port B (base writeback) write
//   pc_inc               : request R15 += PC_STEP
//   wr_ack               : one-cycle pulse after any accepted write
//   wr_collide           : one-cycle pulse after an A/B write to the same register
interface reg_bank_if
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);

    logic             wa_en;
    logic [SEL_W-1:0] wa_sel;
    logic [WIDTH-1:0] wa_data;
    logic             wb_en;
    logic [SEL_W-1:0] wb_sel;
    logic [WIDTH-1:0] wb_data;
    logic             pc_inc;
    logic             wr_ack;
    logic             wr_collide;

    modport master (
        output wa_en, wa_sel, wa_data,
        output wb_en, wb_sel, wb_data,
        output pc_inc,
        input  wr_ack, wr_collide
    );

    modport slave (
        input  wa_en, wa_sel, wa_data,
        input  wb_en, wb_sel, wb_data,
        input  pc_inc,
        output wr_ack, wr_collide
    );

endinterface : reg_bank_if

// File: rtl/reg_decoder.sv
// 4-to-16 one-hot write-select decoder; all zeros when en is low.
//   sel    : register number
//   en     : write enable
//   onehot : one bit per register, at most one set
module reg_decoder
    import reg_bank_pkg::*;
(
    input  logic [SEL_W-1:0]    sel,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule : reg_decoder

// File: rtl/reg_bank.sv
// Sixteen-entry register bank with two write ports and an auto-incrementing R15.
//   clk, reset_n : clock and synchronous active-low reset
//   bus          : write ports A/B, pc_inc, wr_ack/wr_collide status
//   q0..q15      : registered contents of R0..R15
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] PC_RESET = WIDTH'(PC_RESET_DEF),
    parameter int unsigned      PC_STEP  = PC_STEP_DEF
)
(
    input  logic             clk,
    input  logic             reset_n,
    reg_bank_if.slave        bus,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7,
    output logic [WIDTH-1:0] q8,
    output logic [WIDTH-1:0] q9,
    output logic [WIDTH-1:0] q10,
    output logic [WIDTH-1:0] q11,
    output logic [WIDTH-1:0] q12,
    output logic [WIDTH-1:0] q13,
    output logic [WIDTH-1:0] q14,
    output logic [WIDTH-1:0] q15
);

    logic [NUM_REGS-1:0] hit_a;
    logic [NUM_REGS-1:0] hit_b;
    logic [WIDTH-1:0]    regs [NUM_REGS];
    logic [WIDTH-1:0]    pc_q;

    reg_decoder u_dec_a (.sel(bus.wa_sel), .en(bus.wa_en), .onehot(hit_a));
    reg_decoder u_dec_b (.sel(bus.wb_sel), .en(bus.wb_en), .onehot(hit_b));

    // General registers R0..R14; port A is checked first so it wins a collision.
    for (genvar i = 0; i < int'(PC_IDX); i++) begin : g_gpr
        logic [WIDTH-1:0] r_q;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_q <= '0;
            end else if (hit_a[i]) begin
                r_q <= bus.wa_data;
            end else if (hit_b[i]) begin
                r_q <= bus.wb_data;
            end
        end

        assign regs[i] = r_q;
    end

    // R15: port A > port B > pc_inc > hold; the increment wraps silently.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q <= PC_RESET;
        end else if (hit_a[PC_IDX]) begin
            pc_q <= bus.wa_data;
        end else if (hit_b[PC_IDX]) begin
            pc_q <= bus.wb_data;
        end else if (bus.pc_inc) begin
            pc_q <= pc_q + WIDTH'(PC_STEP);
        end
    end

    assign regs[PC_IDX] = pc_q;

    // Write status pulses; pc_inc alone is not a write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.wr_ack     <= 1'b0;
            bus.wr_collide <= 1'b0;
        end else begin
            bus.wr_ack     <= bus.wa_en | bus.wb_en;
            bus.wr_collide <= bus.wa_en & bus.wb_en & (bus.wa_sel == bus.wb_sel);
        end
    end

    assign q0  = regs[0];
    assign q1  = regs[1];
    assign q2  = regs[2];
    assign q3  = regs[3];
    assign q4  = regs[4];
    assign q5  = regs[5];
    assign q6  = regs[6];
    assign q7  = regs[7];
    assign q8  = regs[8];
    assign q9  = regs[9];
    assign q10 = regs[10];
    assign q11 = regs[11];
    assign q12 = regs[12];
    assign q13 = regs[13];
    assign q14 = regs[14];
    assign q15 = regs[15];

endmodule : reg_bank

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed vector table, a register sweep
// and randomized traffic, all compared against a register-array model.
module tb_reg_bank;

    localparam logic [31:0] PC_RST = 32'h0000_0000;
    localparam int unsigned STEP   = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] qv [16];

    int checks = 0;
    int errors = 0;

    logic [31:0] model [16];
    logic        exp_ack;
    logic        exp_col;

    reg_bank_if #(.WIDTH(32)) bus ();

    reg_bank #(.WIDTH(32), .PC_RESET(PC_RST), .PC_STEP(STEP)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .q0(qv[0]),   .q1(qv[1]),   .q2(qv[2]),   .q3(qv[3]),
        .q4(qv[4]),   .q5(qv[5]),   .q6(qv[6]),   .q7(qv[7]),
        .q8(qv[8]),   .q9(qv[9]),   .q10(qv[10]), .q11(qv[11]),
        .q12(qv[12]), .q13(qv[13]), .q14(qv[14]), .q15(qv[15])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic        wae;
        logic [3:0]  was;
        logic [31:0] wad;
        logic        web;
        logic [3:0]  wbs;
        logic [31:0] wbd;
        logic        pci;
        logic [3:0]  exp_sel;
        logic [31:0] exp_q;
        logic        exp_ack;
        logic        exp_col;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every register and both status bits with the model.
    task automatic check_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s q%0d", tag, i), qv[i], model[i]);
        end
        check({tag, " wr_ack"}, 32'(bus.wr_ack), 32'(exp_ack));
        check({tag, " wr_collide"}, 32'(bus.wr_collide), 32'(exp_col));
    endtask

    // Drive one cycle of inputs, advance the model by the same rules, check.
    task automatic step(input logic rn, input logic wae, input logic [3:0] was,
                        input logic [31:0] wad, input logic web, input logic [3:0] wbs,
                        input logic [31:0] wbd, input logic pci, input string tag);
        reset_n     = rn;
        bus.wa_en   = wae;
        bus.wa_sel  = was;
        bus.wa_data = wad;
        bus.wb_en   = web;
        bus.wb_sel  = wbs;
        bus.wb_data = wbd;
        bus.pc_inc  = pci;
        @(posedge clk);
        if (!rn) begin
            for (int i = 0; i < 16; i++) model[i] = 32'h0;
            model[15] = PC_RST;
            exp_ack = 1'b0;
            exp_col = 1'b0;
        end else begin
            if (web) model[wbs] = wbd;
            if (wae) model[was] = wad;
            if (pci && !(wae && was == 4'd15) && !(web && wbs == 4'd15))
                model[15] = model[15] + STEP;
            exp_ack = wae | web;
            exp_col = wae & web & (was == wbs);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] pc_before;
        logic [3:0]  sa;
        logic [3:0]  sb;

        vecs[0]  = '{1'b0, 1'b1, 4'd3,  32'hDEAD_BEEF, 1'b0, 4'd0,  32'h0,         1'b1, 4'd3,  32'h0,         1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 4'd3,  32'hDEAD_BEEF, 1'b0, 4'd0,  32'h0,         1'b0, 4'd15, PC_RST,        1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 4'd1,  32'h1111_1111, 1'b1, 4'd2,  32'h2222_2222, 1'b0, 4'd1,  32'h1111_1111, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,         1'b0, 4'd2,  32'h2222_2222, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 4'd5,  32'hAAAA_AAAA, 1'b1, 4'd5,  32'h5555_5555, 1'b0, 4'd5,  32'hAAAA_AAAA, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,         1'b0, 4'd5,  32'hAAAA_AAAA, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 4'd15, 32'hFFFF_FFF8, 1'b0, 4'd0,  32'h0,         1'b0, 4'd15, 32'hFFFF_FFF8, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,         1'b1, 4'd15, 32'hFFFF_FFFC, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,         1'b1, 4'd15, 32'h0000_0000, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,         1'b1, 4'd15, 32'h0000_0004, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 4'd0,  32'h0,         1'b1, 4'd15, 32'h0000_0100, 1'b1, 4'd15, 32'h0000_0100, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 4'd15, 32'h0000_0200, 1'b1, 4'd15, 32'h0000_0100, 1'b1, 4'd15, 32'h0000_0200, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 4'd3,  32'h0000_0077, 1'b0, 4'd0,  32'h0,         1'b1, 4'd15, 32'h0000_0204, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,         1'b0, 4'd3,  32'h0000_0077, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) model[i] = 32'hx;
        exp_ack = 1'b0;
        exp_col = 1'b0;

        // Directed vectors: model-checked, plus the explicit expectation per row.
        for (int v = 0; v < 14; v++) begin
            step(vecs[v].rn, vecs[v].wae, vecs[v].was, vecs[v].wad,
                 vecs[v].web, vecs[v].wbs, vecs[v].wbd, vecs[v].pci, $sformatf("vec%0d", v));
            check($sformatf("vec%0d sel", v), qv[vecs[v].exp_sel], vecs[v].exp_q);
            check($sformatf("vec%0d ack", v), 32'(bus.wr_ack), 32'(vecs[v].exp_ack));
            check($sformatf("vec%0d col", v), 32'(bus.wr_collide), 32'(vecs[v].exp_col));
        end

        // Sweep R0..R14 on consecutive cycles, R15 must not move.
        pc_before = 32'h0000_0204;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b1, 4'(i), 32'(i) * 32'h0101_0101, 1'b0, 4'd0, 32'h0, 1'b0,
                 $sformatf("sweep%0d", i));
        end
        for (int i = 0; i < 15; i++) begin
            check($sformatf("sweep hold q%0d", i), qv[i], 32'(i) * 32'h0101_0101);
        end
        check("sweep q15", qv[15], pc_before);

        // Reset with a write in flight, then a write on the first released edge.
        step(1'b0, 1'b1, 4'd7, 32'h1234_5678, 1'b1, 4'd15, 32'h9, 1'b1, "rst_inflight");
        check("rst_inflight q7", qv[7], 32'h0);
        step(1'b1, 1'b1, 4'd7, 32'h1234_5678, 1'b0, 4'd0, 32'h0, 1'b0, "first_write");
        check("first_write q7", qv[7], 32'h1234_5678);

        // Randomized traffic with occasional resets and forced collisions.
        for (int n = 0; n < 600; n++) begin
            sa = 4'($urandom_range(0, 15));
            sb = ($urandom_range(0, 3) == 0) ? sa : 4'($urandom_range(0, 15));
            step(($urandom_range(0, 39) != 0),
                 1'($urandom_range(0, 1)), sa, $urandom(),
                 1'($urandom_range(0, 1)), sb, $urandom(),
                 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_reg_bank
